// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package dff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Ceiling log2, floored at 1 so single-value fields still get a real bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared holding register: requests, writes, grant and contents.
interface dff_reg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int OW = dff_arb_pkg::clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic [WIDTH-1:0]      q;

    modport master (
        output req, we, wdata,
        input  gnt, owner, busy, q
    );

    modport slave (
        input  req, we, wdata,
        output gnt, owner, busy, q
    );

endinterface

// File: rtl/dff_reg_arbiter_pick.sv
// Rotating-priority encoder: first eligible request at or after ptr, wrapping around.
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int OW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   ptr,
    input  logic [NREQ-1:0] excl,
    output logic [OW-1:0]   winner,
    output logic            found
);
    logic [NREQ-1:0]   eligible;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                off;
    int                sum;

    assign eligible = req & ~excl;
    assign dbl      = {eligible, eligible};
    // Bit k of rot is requester (ptr + k) mod NREQ.
    assign rot      = NREQ'(dbl >> ptr);

    always_comb begin
        off   = 0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = k;
                found = 1'b1;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        winner = OW'(sum);
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register, with tenures capped at MAX_HOLD cycles.
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    dff_reg_arbiter_if.slave bus
);
    localparam int OW = clog2(NREQ);
    localparam int HW = clog2(MAX_HOLD);

    arb_state_t       state_reg;
    logic [OW-1:0]    ptr_reg;
    logic [OW-1:0]    owner_reg;
    logic [HW-1:0]    hold_cnt_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] q_reg;

    logic [WIDTH-1:0] wdata_arr [NREQ];
    logic [NREQ-1:0]  owner_onehot;
    logic [NREQ-1:0]  win_onehot;
    logic [OW-1:0]    owner_next_ptr;
    logic [OW-1:0]    pick_ptr;
    logic [NREQ-1:0]  pick_excl;
    logic [OW-1:0]    pick_winner;
    logic             pick_found;
    logic             owner_req;
    logic             owner_we;
    logic             release_now;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign wdata_arr[gi]    = bus.wdata[gi*WIDTH +: WIDTH];
            assign owner_onehot[gi] = (owner_reg == OW'(gi));
            assign win_onehot[gi]   = (pick_winner == OW'(gi));
        end
    endgenerate

    assign owner_req      = bus.req[owner_reg];
    assign owner_we       = bus.we[owner_reg];
    assign owner_next_ptr = (owner_reg == OW'(NREQ - 1)) ? '0 : owner_reg + OW'(1);
    assign release_now    = (state_reg == OWN) &&
                            (!owner_req || (hold_cnt_reg == HW'(MAX_HOLD - 1)));

    // While owning, the only decision that matters is the handoff, which starts after
    // the current owner and never picks it again.
    assign pick_ptr  = (state_reg == OWN) ? owner_next_ptr : ptr_reg;
    assign pick_excl = (state_reg == OWN) ? owner_onehot : '0;

    rr_priority_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .excl   (pick_excl),
        .winner (pick_winner),
        .found  (pick_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
            busy_reg     <= 1'b0;
            q_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        gnt_reg      <= win_onehot;
                        owner_reg    <= pick_winner;
                        busy_reg     <= 1'b1;
                        hold_cnt_reg <= '0;
                        state_reg    <= OWN;
                    end
                end
                OWN: begin
                    // The write is honoured even on the edge where the owner lets go.
                    if (owner_we) begin
                        q_reg <= wdata_arr[owner_reg];
                    end
                    if (release_now) begin
                        ptr_reg <= owner_next_ptr;
                        if (pick_found) begin
                            gnt_reg      <= win_onehot;
                            owner_reg    <= pick_winner;
                            hold_cnt_reg <= '0;
                        end else begin
                            gnt_reg   <= '0;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = busy_reg;
    assign bus.q     = q_reg;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed and randomized checks of dff_reg_arbiter against a tenure-level reference model.
module tb_dff_reg_arbiter;
    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dff_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    dff_reg_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the register, how many cycles of this tenure are used,
    // where the next search starts, and what the register holds.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_used;
    logic [7:0] m_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start, input int skip);
        for (int k = 0; k < NREQ; k++) begin
            int idx = (start + k) % NREQ;
            if (r[idx] && idx != skip) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_used  = 0;
        m_q     = 8'h00;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] w, input logic [31:0] wd);
        int win;
        if (!m_busy) begin
            win = pick(r, m_ptr, -1);
            if (win >= 0) begin
                m_busy  = 1'b1;
                m_owner = win;
                m_used  = 1;
            end
        end else begin
            if (w[m_owner]) m_q = wd[m_owner*8 +: 8];
            if (!r[m_owner] || m_used == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % NREQ;
                win   = pick(r, m_ptr, m_owner);
                if (win >= 0) begin
                    m_owner = win;
                    m_used  = 1;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_used++;
            end
        end
    endtask

    task automatic compare_model();
        check("gnt", {28'd0, bus.gnt}, m_busy ? (32'd1 << m_owner) : 32'd0);
        check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        if (m_busy) check("owner", {30'd0, bus.owner}, m_owner);
        check("q", {24'd0, bus.q}, {24'd0, m_q});
        check("onehot", {31'd0, ($countones(bus.gnt) <= 1)}, 32'd1);
        $display("[TB] t=%0t req=%b we=%b gnt=%b owner=%0d busy=%b q=%h", $time,
                 bus.req, bus.we, bus.gnt, bus.owner, bus.busy, bus.q);
    endtask

    task automatic tick();
        logic [3:0]  r;
        logic [3:0]  w;
        logic [31:0] wd;
        r  = bus.req;
        w  = bus.we;
        wd = bus.wdata;
        @(posedge clk);
        model_edge(r, w, wd);
        #1;
        compare_model();
    endtask

    initial begin
        rst       = 1'b0;
        bus.req   = '0;
        bus.we    = '0;
        bus.wdata = '0;
        model_reset();
        #12;
        check("rst_gnt", {28'd0, bus.gnt}, 32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        check("rst_owner", {30'd0, bus.owner}, 32'h0);
        check("rst_q", {24'd0, bus.q}, 32'h0);
        rst = 1'b1;

        // Single requester: grant one cycle after req, write one cycle after grant.
        bus.req   = 4'b0100;
        bus.we    = 4'b0100;
        bus.wdata = 32'h00C3_0000;
        tick();
        check("single_gnt", {28'd0, bus.gnt}, 32'b0100);
        check("single_owner", {30'd0, bus.owner}, 32'd2);
        tick();
        check("single_q", {24'd0, bus.q}, 32'hC3);
        bus.req = 4'b0000;
        bus.we  = 4'b0000;
        tick();
        check("single_release", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of a tenure.
        bus.req = 4'b0010;
        tick();
        check("pre_rst_gnt", {28'd0, bus.gnt}, 32'b0010);
        bus.we    = 4'b0010;
        bus.wdata = 32'h0000_5A00;
        tick();
        check("pre_rst_q", {24'd0, bus.q}, 32'h5A);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_gnt", {28'd0, bus.gnt}, 32'h0);
        check("async_rst_busy", {31'd0, bus.busy}, 32'h0);
        check("async_rst_q", {24'd0, bus.q}, 32'h0);
        bus.req = 4'b0000;
        bus.we  = 4'b0000;
        #2;
        rst = 1'b1;

        // Full load: back-to-back tenures of MAX_HOLD cycles in rotation.
        bus.req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("rr_owner", {30'd0, bus.owner}, (c / 4) % 4);
            check("rr_gnt", {28'd0, bus.gnt}, 32'd1 << ((c / 4) % 4));
        end

        // Early release hands off directly to requester 3.
        bus.req = 4'b0000;
        tick();
        check("rr_idle", {31'd0, bus.busy}, 32'd0);
        bus.req = 4'b1010;
        tick();
        check("early_gnt1", {28'd0, bus.gnt}, 32'b0010);
        tick();
        bus.req = 4'b1000;
        tick();
        check("early_handoff", {28'd0, bus.gnt}, 32'b1000);

        // Owner 3 releases with no requests; pointer wraps to 0.
        bus.req = 4'b0000;
        tick();
        check("wrap_idle", {31'd0, bus.busy}, 32'd0);
        bus.req   = 4'b0011;
        bus.we    = 4'b0001;
        bus.wdata = 32'h0000_00A5;
        tick();
        check("wrap_owner", {30'd0, bus.owner}, 32'd0);
        tick();
        check("wrap_q", {24'd0, bus.q}, 32'hA5);

        // Non-owner writes are ignored.
        bus.req = 4'b0000;
        bus.we  = 4'b0000;
        tick();
        bus.req   = 4'b0100;
        bus.we    = 4'b0001;
        bus.wdata = 32'h0000_00FF;
        tick();
        check("iso_owner", {30'd0, bus.owner}, 32'd2);
        tick();
        tick();
        check("iso_q", {24'd0, bus.q}, 32'hA5);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            bus.req   = 4'($urandom_range(0, 15));
            bus.we    = 4'($urandom_range(0, 15));
            bus.wdata = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                #3;
                rst = 1'b0;
                #1;
                model_reset();
                compare_model();
                #1;
                rst = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
